serial_adder_controller: RTL and testbench

Bit-serial adder sequencer: accepts two WIDTH-bit operands over a valid/ready handshake and reuses a single `full_adder` instance once per bit, LSB first, across WIDTH cycles. It holds the running carry in a register between cycles. It presents the WIDTH-bit sum with carry-out and signed-overflow flags over a second valid/ready handshake. The block is the area-minimal alternative to a ripple chain of `full_adder`s and is the first sequential client of the adder primitives.

---
 rtl/serial_adder_controller_if.sv | 40 ++++
 rtl/serial_adder_controller.sv | 119 +++++++++++
 tb/tb_serial_adder_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_adder_controller_if.sv
// Handshake bundle for serial_adder_controller: operand request channel and result channel.
// The optional `sub` signal exists only when SERIAL_SUB_EN is defined.
interface serial_adder_controller_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    // master: requester/consumer side; slave: the sequencer itself
    modport master (
        output start_valid, output left, output right,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        output result_ready,
        input  start_ready, input result_valid, input sum,
        input  carry_out, input overflow, input busy
    );

    modport slave (
        input  start_valid, input left, input right,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        input  result_ready,
        output start_ready, output result_valid, output sum,
        output carry_out, output overflow, output busy
    );
endinterface

// File: rtl/serial_adder_controller.sv
// Bit-serial adder: one full_adder reused LSB-first over WIDTH cycles.
// Define SERIAL_SUB_EN to add the `sub` request (two's-complement subtract).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input logic                      clock,
    input logic                      reset,
    serial_adder_controller_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] left_sr, right_sr, sum_sr, sum_q;
    logic [CNT_W-1:0] count;
    logic             carry_q, carry_out_q, overflow_q, sub_q;
    logic             accept, last_bit, fa_b, fa_s, fa_c;
    logic [WIDTH:0]   sum_ext;

    assign accept   = bus.start_valid && (state == IDLE);
    assign last_bit = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    assign fa_b     = right_sr[0] ^ sub_q;
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign sum_ext  = {fa_s, sum_sr};

    full_adder u_fa (
        .a    (left_sr[0]),
        .b    (fa_b),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next state gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (bus.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifndef SERIAL_SUB_EN
    assign sub_q = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            left_sr     <= '0;
            right_sr    <= '0;
            sum_sr      <= '0;
            sum_q       <= '0;
            count       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        left_sr  <= bus.left;
                        right_sr <= bus.right;
                        count    <= '0;
`ifdef SERIAL_SUB_EN
                        sub_q    <= bus.sub;
                        carry_q  <= bus.sub;
`else
                        carry_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    left_sr  <= left_sr >> 1;
                    right_sr <= right_sr >> 1;
                    sum_sr   <= sum_ext[WIDTH:1];
                    carry_q  <= fa_c;
                    count    <= count + CNT_W'(1);
                    if (last_bit) begin
                        sum_q       <= sum_ext[WIDTH:1];
                        carry_out_q <= fa_c;
                        // carry_q is the carry into the MSB, fa_c the carry out of it
                        overflow_q  <= carry_q ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready  = (state == IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.busy         = (state != IDLE);
    assign bus.sum          = sum_q;
    assign bus.carry_out    = carry_out_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed self-checking bench for serial_adder_controller (WIDTH=8);
// subtract vectors run only when SERIAL_SUB_EN is defined.
module tb_serial_adder_controller;
    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_adder_controller_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_controller #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start_valid  = 1'b0;
        bus.left         = '0;
        bus.right        = '0;
        bus.result_ready = 1'b0;
`ifdef SERIAL_SUB_EN
        bus.sub          = 1'b0;
`endif
    endtask

    // Full operation: accept, wait for result, optionally hold off the consumer,
    // optionally poke start_valid during RUN, then consume and check return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] exp_sum, input logic exp_co,
                          input logic exp_ov, input int hold, input logic inject);
        int cyc;
        @(negedge clock);
        check({tag, ".ready"}, 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.left        = a;
        bus.right       = b;
`ifdef SERIAL_SUB_EN
        bus.sub         = s;
`else
        if (s) $display("note: %s requests subtract without SERIAL_SUB_EN", tag);
`endif
        @(negedge clock);
        drive_idle();
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check({tag, ".rv_low"}, 32'(bus.result_valid), 32'd0);
        cyc = 0;
        while (!bus.result_valid && cyc < 50) begin
            if (inject && cyc == 2) begin
                bus.start_valid = 1'b1;
                bus.left        = 8'h11;
                bus.right       = 8'h22;
            end else if (inject && cyc == 3) begin
                drive_idle();
            end
            @(negedge clock);
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(WIDTH));
        check({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, ".carry"}, 32'(bus.carry_out), 32'(exp_co));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(exp_ov));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, ".hold_rv"}, 32'(bus.result_valid), 32'd1);
            check({tag, ".hold_out"}, {22'd0, bus.overflow, bus.carry_out, bus.sum},
                  {22'd0, exp_ov, exp_co, exp_sum});
        end
        bus.result_ready = 1'b1;
        @(negedge clock);
        bus.result_ready = 1'b0;
        check({tag, ".idle_ready"}, 32'(bus.start_ready), 32'd1);
        check({tag, ".idle_rv"}, 32'(bus.result_valid), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        drive_idle();
        #1;
        check("reset.ready", 32'(bus.start_ready), 32'd1);
        check("reset.rv", 32'(bus.result_valid), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.outs", {22'd0, bus.overflow, bus.carry_out, bus.sum}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        run_op("bp_inject", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 5, 1'b1);

        // Abort mid-RUN with an asynchronous reset pulse between clock edges.
        @(negedge clock);
        bus.start_valid = 1'b1;
        bus.left        = 8'h33;
        bus.right       = 8'h44;
        @(negedge clock);
        drive_idle();
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort.ready", 32'(bus.start_ready), 32'd1);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.rv", 32'(bus.result_valid), 32'd0);
        check("abort.outs", {22'd0, bus.overflow, bus.carry_out, bus.sum}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort.idle", 32'(bus.start_ready), 32'd1);
        run_op("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_SUB_EN
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
